// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes into little-endian 32-bit words, writes them to
// consecutive instruction-memory addresses, then hands the memory to the core.
//
// state   | meaning
// S_LOAD  | collecting bytes of the current word
// S_WRITE | one-cycle write of the assembled word
// S_DONE  | load finished; core owns the read port and runs
module uart_imem_loader #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] END_WORD = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_break,
  input  logic [ADDR_W-1:0] cpu_imem_addr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              write_done,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {S_LOAD, S_WRITE, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_byte_idx;
  logic [31:0]         r_shift;
  logic [31:0]         r_wdata;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_count;
  logic [31:0]         w_word;
  logic                w_take;
  logic                w_word_end;

  // byte_idx is always 0 in S_WRITE, so a byte arriving there lands in lane 0
  always_comb begin
    w_word = r_shift;
    case (r_byte_idx)
      2'd0:    w_word[7:0]   = uart_rx_data;
      2'd1:    w_word[15:8]  = uart_rx_data;
      2'd2:    w_word[23:16] = uart_rx_data;
      default: w_word[31:24] = uart_rx_data;
    endcase
  end

  assign w_take     = uart_rx_valid && !uart_rx_break && (r_state != S_DONE);
  assign w_word_end = w_take && (r_byte_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    imem_we     = 1'b0;
    imem_addr   = r_ptr;
    imem_wdata  = r_wdata;
    write_done  = 1'b0;
    cpu_rst     = 1'b1;
    word_count  = r_count;
    case (r_state)
      S_LOAD: begin
        if (w_word_end) w_state_nxt = (w_word == END_WORD) ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        imem_we     = 1'b1;
        w_state_nxt = (r_ptr == {ADDR_W{1'b1}}) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        imem_addr  = cpu_imem_addr;
        write_done = 1'b1;
        cpu_rst    = 1'b0;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // r_shift and r_wdata are separate so the next word can start during S_WRITE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_idx <= 2'd0;
      r_shift    <= 32'h0;
      r_wdata    <= 32'h0;
      r_ptr      <= '0;
      r_count    <= '0;
    end else begin
      if (r_state != S_DONE && uart_rx_break) begin
        r_byte_idx <= 2'd0;
      end else if (w_take) begin
        r_shift    <= w_word;
        r_byte_idx <= r_byte_idx + 2'd1;
        if (w_word_end && w_word != END_WORD) r_wdata <= w_word;
      end
      if (r_state == S_WRITE) begin
        r_ptr   <= r_ptr + 1'b1;
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: two instances (256-word and 4-word memories) share
// stimulus and are checked every cycle against a byte-queue model of the loader.
module tb_uart_imem_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        v = 1'b0;
  logic        brk = 1'b0;
  logic [7:0]  d = 8'h00;
  logic [7:0]  cpu_a = 8'h00;

  logic        we0, done0, crst0;
  logic [7:0]  addr0;
  logic [31:0] wd0;
  logic [8:0]  cnt0;
  logic        we1, done1, crst1;
  logic [1:0]  addr1;
  logic [31:0] wd1;
  logic [2:0]  cnt1;

  uart_imem_loader #(.ADDR_W(8)) dut0 (
    .clk(clk), .rst(rst), .uart_rx_valid(v), .uart_rx_data(d), .uart_rx_break(brk),
    .cpu_imem_addr(cpu_a), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0),
    .write_done(done0), .cpu_rst(crst0), .word_count(cnt0));

  uart_imem_loader #(.ADDR_W(2)) dut1 (
    .clk(clk), .rst(rst), .uart_rx_valid(v), .uart_rx_data(d), .uart_rx_break(brk),
    .cpu_imem_addr(cpu_a[1:0]), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1),
    .write_done(done1), .cpu_rst(crst1), .word_count(cnt1));

  int n_cmp = 0;
  int n_err = 0;

  int          m_cap [2] = '{256, 4};
  bit          m_done[2];
  int          m_nb  [2];
  logic [31:0] m_acc [2];
  bit          m_we  [2];
  logic [31:0] m_wd  [2];
  int          m_cnt [2];

  int          log0_a[$];
  logic [31:0] log0_d[$];
  int          log1_a[$];
  logic [31:0] log1_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    bit was;
    if (rst) begin
      m_done[i] = 0; m_nb[i] = 0; m_acc[i] = 0; m_we[i] = 0; m_wd[i] = 0; m_cnt[i] = 0;
      return;
    end
    if (m_done[i]) return;
    was = m_we[i];
    m_we[i] = 0;
    if (was) begin
      m_cnt[i]++;
      if (m_cnt[i] == m_cap[i]) begin
        m_done[i] = 1;
        return;
      end
    end
    if (brk) begin
      m_nb[i] = 0; m_acc[i] = 0;
    end else if (v) begin
      m_acc[i] = m_acc[i] | (32'(d) << (8 * m_nb[i]));
      m_nb[i]++;
      if (m_nb[i] == 4) begin
        if (m_acc[i] == 32'hFFFFFFFF) m_done[i] = 1;
        else begin
          m_we[i] = 1; m_wd[i] = m_acc[i];
        end
        m_nb[i] = 0; m_acc[i] = 0;
      end
    end
  endtask

  task automatic cmp_dut(input int i, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic done, input logic crst,
                         input logic [31:0] cnt);
    int ea;
    ea = m_done[i] ? (int'(cpu_a) % m_cap[i]) : (m_cnt[i] % m_cap[i]);
    chk($sformatf("dut%0d.imem_we", i), 32'(we), 32'(m_we[i]));
    chk($sformatf("dut%0d.imem_addr", i), addr, ea);
    chk($sformatf("dut%0d.write_done", i), 32'(done), 32'(m_done[i]));
    chk($sformatf("dut%0d.cpu_rst", i), 32'(crst), 32'(!m_done[i]));
    chk($sformatf("dut%0d.word_count", i), cnt, m_cnt[i]);
    if (m_we[i]) chk($sformatf("dut%0d.imem_wdata", i), wd, m_wd[i]);
  endtask

  task automatic compare_all();
    cmp_dut(0, we0, 32'(addr0), wd0, done0, crst0, 32'(cnt0));
    cmp_dut(1, we1, 32'(addr1), wd1, done1, crst1, 32'(cnt1));
    if (we0) begin log0_a.push_back(int'(addr0)); log0_d.push_back(wd0); end
    if (we1) begin log1_a.push_back(int'(addr1)); log1_d.push_back(wd1); end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare_all();
    v = 1'b0;
    brk = 1'b0;
  endtask

  task automatic clear_logs();
    log0_a.delete(); log0_d.delete(); log1_a.delete(); log1_d.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic send_byte(input logic [7:0] b);
    v = 1'b1;
    d = b;
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      idle(gap);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".we"}, 32'(we0), 0);
    chk({tag, ".addr"}, 32'(addr0), 0);
    chk({tag, ".wdata"}, wd0, 0);
    chk({tag, ".done"}, 32'(done0), 0);
    chk({tag, ".cpu_rst"}, 32'(crst0), 1);
    chk({tag, ".count"}, 32'(cnt0), 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk_reset_vals("reset");
    chk("reset.d1.count", 32'(cnt1), 0);

    // two ordinary words with idle gaps between bytes
    send_word(32'hfe010113, 2);
    send_word(32'h00812e23, 1);
    idle(2);
    chk("t1.nwrites", log0_a.size(), 2);
    chk("t1.addr0", log0_a[0], 0);
    chk("t1.data0", log0_d[0], 32'hfe010113);
    chk("t1.addr1", log0_a[1], 1);
    chk("t1.data1", log0_d[1], 32'h00812e23);
    chk("t1.count", 32'(cnt0), 2);
    chk("t1.cpu_rst", 32'(crst0), 1);

    // end marker, then a second marker that must be ignored
    do_reset();
    send_word(32'h11223344, 0);
    send_word(32'h55667788, 1);
    send_word(32'h01020304, 0);
    idle(1);
    send_word(32'hFFFFFFFF, 0);
    chk("t2.done", 32'(done0), 1);
    chk("t2.cpu_rst", 32'(crst0), 0);
    send_word(32'hFFFFFFFF, 0);
    idle(2);
    chk("t2.nwrites", log0_a.size(), 3);
    chk("t2.count", 32'(cnt0), 3);

    // break discards a partial word
    do_reset();
    send_byte(8'hAA);
    send_byte(8'hBB);
    brk = 1'b1;
    tick();
    send_word(32'h12345678, 0);
    idle(2);
    chk("t3.nwrites", log0_a.size(), 1);
    chk("t3.addr", log0_a[0], 0);
    chk("t3.data", log0_d[0], 32'h12345678);

    // memory full on the 4-word instance
    do_reset();
    for (int k = 1; k <= 5; k++) send_word(32'h11111111 * k, 0);
    idle(2);
    chk("t4.d1.nwrites", log1_a.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4.d1.addr%0d", k), log1_a[k], k);
      chk($sformatf("t4.d1.data%0d", k), log1_d[k], 32'h11111111 * (k + 1));
    end
    chk("t4.d1.done", 32'(done1), 1);
    chk("t4.d1.count", 32'(cnt1), 4);
    chk("t4.d0.nwrites", log0_a.size(), 5);

    // eight back-to-back bytes across a write cycle
    do_reset();
    for (int k = 1; k <= 8; k++) send_byte(8'(k));
    idle(2);
    chk("t5.nwrites", log0_a.size(), 2);
    chk("t5.data0", log0_d[0], 32'h04030201);
    chk("t5.data1", log0_d[1], 32'h08070605);

    // reset in the middle of a word, reload, then hand over to the core
    do_reset();
    send_word(32'hCAFEF00D, 0);
    send_byte(8'h01);
    send_byte(8'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("t6.midrst");
    clear_logs();
    send_word(32'h0BADBEEF, 0);
    idle(1);
    chk("t6.nwrites", log0_a.size(), 1);
    chk("t6.addr", log0_a[0], 0);
    send_word(32'hFFFFFFFF, 0);
    cpu_a = 8'd5;
    #1;
    chk("t6.cpu_addr", 32'(addr0), 5);
    chk("t6.we", 32'(we0), 0);
    idle(1);

    // randomized traffic
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int c = 0; c < 600; c++) begin
        cpu_a = 8'($urandom);
        v = ($urandom_range(0, 2) != 0);
        d = (($urandom_range(0, 3) == 0) || c > 450) ? 8'hFF : 8'($urandom);
        brk = (!m_we[0] && !m_we[1] && $urandom_range(0, 39) == 0);
        rst = ($urandom_range(0, 499) == 0);
        tick();
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
